// File: rtl/hv_pkg.sv
// Shared constants and types for the hypervector result path.
package hv_pkg;

  // Output word width; the packer and its consumers assume 32.
  localparam int unsigned WORD_W = 32;

  // Depth of the per-dimension counter update pipeline.
  localparam int unsigned CNT_PIPE_LAT = 3;

  typedef enum logic {IDLE, SEND} pack_state_t;

  // Number of WORD_W-bit words needed to carry DIM sign bits.
  function automatic int unsigned nwords(input int unsigned dim);
    return dim / WORD_W;
  endfunction

endpackage

// File: rtl/hv_pulse_delay.sv
// Fixed-latency pulse delay line with synchronous flush. Each input pulse
// re-emerges Depth cycles later, so back-to-back pulses stay distinct.
module hv_pulse_delay #(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_i,
  input  logic flush_i,
  output logic pulse_o
);

  if (Depth < 1) begin : g_bad_depth
    $error("hv_pulse_delay: Depth must be >= 1");
  end

  logic [Depth-1:0] sr_q, sr_d;

  // Shift the pulse one stage per cycle; flush wipes every stage.
  always_comb begin
    sr_d    = '0;
    sr_d[0] = pulse_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    if (flush_i) begin
      sr_d = '0;
    end
  end

  // Delay line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign pulse_o = sr_q[Depth-1];

endmodule

// File: rtl/hv_sign_packer.sv
// Snapshots the DIM counter sign bits a fixed delay after the final bundling
// update and streams them out as 32-bit words over valid/ready.
// Optional feature: define HV_SIGN_PACKER_POPCNT_EN to add dout_popcnt, the
// number of set bits in the snapshot, presented with the last word.
module hv_sign_packer
  import hv_pkg::*;
#(
  parameter int unsigned DIM           = 1024,
  parameter int unsigned CAPTURE_DELAY = CNT_PIPE_LAT + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acc_last,
  input  logic                       clear,
  input  logic [DIM-1:0]             sign_bits,
  output logic [WORD_W-1:0]          dout_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_last,
`ifdef HV_SIGN_PACKER_POPCNT_EN
  output logic [$clog2(DIM+1)-1:0]   dout_popcnt,
`endif
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned NWORDS = nwords(DIM);
  localparam int unsigned IdxW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  if ((DIM == 0) || ((DIM % WORD_W) != 0)) begin : g_bad_dim
    $error("hv_sign_packer: DIM must be a non-zero multiple of WORD_W");
  end

  pack_state_t       state_q, state_d;
  logic [DIM-1:0]    snap_q, snap_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic              cap;
  logic              load;
  logic              hs;
  logic              is_last;
  logic [WORD_W-1:0] word_cur;

  // Aligns acc_last with the moment the counters hold their final value.
  hv_pulse_delay #(
    .Depth (CAPTURE_DELAY)
  ) u_cap_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_i (acc_last),
    .flush_i (clear),
    .pulse_o (cap)
  );

  // Select the current word of the snapshot.
  always_comb begin
    word_cur = '0;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (idx_q == IdxW'(w)) begin
        word_cur = snap_q[w*WORD_W +: WORD_W];
      end
    end
  end

  assign is_last = (idx_q == LastIdx);
  assign hs      = (state_q == SEND) && dout_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, snapshot load, word index and overrun tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cap) begin
            load    = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (hs && is_last) begin
            idx_d = '0;
            if (cap) begin
              // New frame starts right behind the old one, no valid gap.
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (hs) begin
              idx_d = idx_q + 1'b1;
            end
            if (cap) begin
              // Frame still in flight: the new snapshot is dropped.
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign snap_d = load ? sign_bits : snap_q;

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q    <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  // Stream outputs; all derive from registers so they hold under backpressure.
  always_comb begin
    dout_valid = (state_q == SEND);
    busy       = (state_q == SEND);
    dout_last  = (state_q == SEND) && is_last;
    dout_data  = word_cur;
    overrun    = overrun_q;
  end

`ifdef HV_SIGN_PACKER_POPCNT_EN
  localparam int unsigned PopW = $clog2(DIM + 1);

  logic [PopW-1:0] pop_q, pop_d;
  logic [PopW-1:0] word_pop;

  // Ones in the word currently presented.
  always_comb begin
    word_pop = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      word_pop = word_pop + PopW'(word_cur[i]);
    end
  end

  // Running sum over words already accepted in this frame.
  always_comb begin
    pop_d = pop_q;
    if (clear || load) begin
      pop_d = '0;
    end else if (hs && !is_last) begin
      pop_d = pop_q + word_pop;
    end
  end

  // Popcount accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q <= '0;
    end else begin
      pop_q <= pop_d;
    end
  end

  // The total is only meaningful alongside the final word.
  always_comb begin
    dout_popcnt = ((state_q == SEND) && is_last) ? (pop_q + word_pop) : '0;
  end
`endif

endmodule
